// File: rtl/write_port_arbiter8.sv
// Eight-requester round-robin write-port arbiter with registered outputs.
// Optional grant watchdog compiled in with the ARB_TIMEOUT_EN macro.
module write_port_arbiter8 #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] ptr_r;
    logic [2:0] ptr_nxt_s;
    logic [2:0] gnt_idx_r;
    logic [2:0] gnt_idx_nxt_s;
    logic [7:0] gnt_r;
    logic [7:0] gnt_nxt_s;
    logic       gnt_valid_r;
    logic       gnt_valid_nxt_s;
    logic [3:0] pick_s;
    logic       release_s;
    logic       expire_s;

    if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_timeout_range
        $error("write_port_arbiter8: TIMEOUT must lie in 2..255");
    end

    // First set bit at or above p, wrapping; MSB of the result flags a hit.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'(8'h01 << idx);
    endfunction

    assign pick_s    = rr_pick(req, ptr_r);
    assign release_s = (state_r == ST_GRANT) && (done || !req[gnt_idx_r]);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST_C = 8'(TIMEOUT - 1);

    logic [7:0] wd_cnt_r;
    logic       timeout_r;

    // Watchdog: zero in every non-GRANT cycle, so it reads 0 on the first GRANT cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_r <= 8'd0;
        end else if (state_r == ST_GRANT) begin
            wd_cnt_r <= wd_cnt_r + 8'd1;
        end else begin
            wd_cnt_r <= 8'd0;
        end
    end

    // Done/abandon outrank the watchdog on the same cycle.
    assign expire_s = (state_r == ST_GRANT) && !release_s && (wd_cnt_r == TO_LAST_C);

    // Timeout pulse lands in the RELEASE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= expire_s;
        end
    end

    assign timeout = timeout_r;
`else
    assign expire_s = 1'b0;
    assign timeout  = 1'b0;
`endif

    // State and registered-output update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            ptr_r       <= 3'd0;
            gnt_idx_r   <= 3'd0;
            gnt_r       <= 8'h00;
            gnt_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            ptr_r       <= ptr_nxt_s;
            gnt_idx_r   <= gnt_idx_nxt_s;
            gnt_r       <= gnt_nxt_s;
            gnt_valid_r <= gnt_valid_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_s[3]) begin
                    state_nxt_s = ST_GRANT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (release_s || expire_s) begin
                    state_nxt_s = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            ST_RELEASE: state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and the search pointer.
    always_comb begin
        ptr_nxt_s       = ptr_r;
        gnt_idx_nxt_s   = gnt_idx_r;
        gnt_nxt_s       = gnt_r;
        gnt_valid_nxt_s = gnt_valid_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_s[3]) begin
                    gnt_idx_nxt_s   = pick_s[2:0];
                    gnt_nxt_s       = onehot8(pick_s[2:0]);
                    gnt_valid_nxt_s = 1'b1;
                end else begin
                    gnt_nxt_s       = 8'h00;
                    gnt_valid_nxt_s = 1'b0;
                end
            end
            ST_GRANT: begin
                if (release_s || expire_s) begin
                    ptr_nxt_s       = gnt_idx_r + 3'd1;
                    gnt_nxt_s       = 8'h00;
                    gnt_valid_nxt_s = 1'b0;
                end else begin
                    gnt_nxt_s       = onehot8(gnt_idx_r);
                    gnt_valid_nxt_s = 1'b1;
                end
            end
            ST_RELEASE: begin
                gnt_nxt_s       = 8'h00;
                gnt_valid_nxt_s = 1'b0;
            end
            default: begin
                gnt_nxt_s       = 8'h00;
                gnt_valid_nxt_s = 1'b0;
            end
        endcase
    end

    assign gnt       = gnt_r;
    assign gnt_idx   = gnt_idx_r;
    assign gnt_valid = gnt_valid_r;

endmodule

// File: tb/tb_write_port_arbiter8.sv
// Directed self-checking bench for write_port_arbiter8 (TIMEOUT=4).
module tb_write_port_arbiter8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [2:0] last_idx;

    write_port_arbiter8 #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] e_gnt, input logic e_valid,
                           input logic e_to);
        chk({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
        chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(e_valid));
        chk({tag, ".timeout"}, 32'(timeout), 32'(e_to));
        chk({tag, ".gnt_idx"}, 32'(gnt_idx), 32'(last_idx));
    endtask

    task automatic exp_grant(input string tag, input logic [2:0] idx);
        logic [7:0] oh;
        oh = 8'h01;
        oh = 8'(oh << idx);
        last_idx = idx;
        chk_out(tag, oh, 1'b1, 1'b0);
    endtask

    task automatic exp_idle(input string tag);
        chk_out(tag, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        reset_n  = 1'b0;
        req      = 8'h00;
        done     = 1'b0;
        last_idx = 3'd0;
        repeat (2) @(negedge clk);
        exp_idle("reset");
        reset_n = 1'b1;

        // No requests; a stray done while idle must be ignored.
        for (int i = 0; i < 5; i++) begin
            done = (i == 2);
            @(negedge clk);
            exp_idle("idle_noreq");
        end
        done = 1'b0;

        // Full request vector: 0..7 then wrap to 0, release + idle gap each time.
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            exp_grant("rr_ff", 3'(k % 8));
            done = 1'b1;
            @(negedge clk);
            exp_idle("rr_release");
            done = 1'b0;
            @(negedge clk);
            exp_idle("rr_gap");
        end

        // Move the pointer to 7, then req=81 grants 7 and wraps to 0.
        req = 8'h40;
        @(negedge clk);
        exp_grant("ptr_to_7", 3'd6);
        done = 1'b1;
        @(negedge clk);
        exp_idle("ptr_to_7_rel");
        done = 1'b0;
        req  = 8'h81;
        @(negedge clk);
        exp_idle("wrap_idle");
        @(negedge clk);
        exp_grant("wrap_7", 3'd7);
        done = 1'b1;
        @(negedge clk);
        exp_idle("wrap_rel");
        done = 1'b0;
        @(negedge clk);
        exp_idle("wrap_gap");
        @(negedge clk);
        exp_grant("wrap_0", 3'd0);

        // Other req bits toggling must not disturb the current grant.
        req = 8'h0F;
        @(negedge clk);
        exp_grant("hold_other_a", 3'd0);
        req = 8'h05;
        @(negedge clk);
        exp_grant("hold_other_b", 3'd0);
        done = 1'b1;
        @(negedge clk);
        exp_idle("hold_rel");
        done = 1'b0;
        req  = 8'h00;
        @(negedge clk);
        exp_idle("hold_gap");

        // Abandon: drop req[4] without done; pointer must move to 5.
        req = 8'h10;
        @(negedge clk);
        exp_grant("abandon_grant", 3'd4);
        req = 8'h00;
        @(negedge clk);
        exp_idle("abandon_rel");
        @(negedge clk);
        exp_idle("abandon_gap");
        req = 8'h21;
        @(negedge clk);
        exp_grant("ptr_after_abandon", 3'd5);
        done = 1'b1;
        @(negedge clk);
        exp_idle("p5_rel");
        done = 1'b0;
        req  = 8'h00;
        @(negedge clk);
        exp_idle("p5_gap");

        req = 8'h04;
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            exp_grant("wd_hold", 3'd2);
        end
        @(negedge clk);
        chk_out("wd_fire", 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        exp_idle("wd_after");
        @(negedge clk);
        exp_grant("wd_regrant", 3'd2);
        repeat (2) begin
            @(negedge clk);
            exp_grant("wd_regrant_hold", 3'd2);
        end
        @(negedge clk);
        exp_grant("wd_last_cycle", 3'd2);
        done = 1'b1;
        @(negedge clk);
        exp_idle("wd_done_wins");
        done = 1'b0;
        req  = 8'h00;
        @(negedge clk);
        exp_idle("wd_done_gap");
`else
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            exp_grant("no_wd_hold", 3'd2);
        end
        done = 1'b1;
        @(negedge clk);
        exp_idle("no_wd_rel");
        done = 1'b0;
        req  = 8'h00;
        @(negedge clk);
        exp_idle("no_wd_gap");
`endif

        // Asynchronous reset in the middle of a grant.
        req = 8'h08;
        @(negedge clk);
        exp_grant("pre_reset", 3'd3);
        #2;
        reset_n = 1'b0;
        #1;
        last_idx = 3'd0;
        exp_idle("async_reset");
        @(negedge clk);
        exp_idle("reset_hold");
        reset_n = 1'b1;
        req     = 8'hFF;
        @(negedge clk);
        exp_grant("post_reset", 3'd0);
        req = 8'h00;
        @(negedge clk);
        exp_idle("post_reset_rel");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/write_port_arbiter8.md
WRITE_PORT_ARBITER8 -- requirements
Module: write_port_arbiter8

Interface
REQ-001 TIMEOUT, default 15, grant watchdog limit in cycles; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  8  per-requester write-port request; bit i is requester i.
REQ-005 done  input  1  granted requester has finished its transfer; sampled only in GRANT.
REQ-006 gnt  output  8  one-hot grant; the 3:8 decode of gnt_idx gated by gnt_valid.
REQ-007 gnt_idx  output  3  binary index of the granted requester.
REQ-008 gnt_valid  output  1  a grant is active.
REQ-009 timeout  output  1  one-cycle pulse when the watchdog revokes a grant.

Function
REQ-010 The block SHALL implement three states: IDLE, GRANT and RELEASE; all outputs SHALL be registered.
REQ-011 In IDLE with req nonzero, the block SHALL select the first set bit of req searching circularly upward from ptr, load gnt_idx and enter GRANT on the next edge (1-cycle request-to-grant latency).
REQ-012 In IDLE with req zero, the block SHALL stay in IDLE with gnt=0, gnt_valid=0.
REQ-013 In GRANT, gnt SHALL equal exactly one bit, at position gnt_idx, and SHALL hold stable until release.
REQ-014 In GRANT, done=1, or req[gnt_idx]=0 (abandon), SHALL cause a transition to RELEASE on the next edge; if both occur together it SHALL be treated as a single release.
REQ-015 On leaving GRANT, ptr SHALL become gnt_idx+1 modulo 8 (7 wraps to 0).
REQ-016 RELEASE SHALL last exactly one cycle with gnt=0, gnt_valid=0, then return to IDLE; minimum grant-to-grant spacing is 1 idle cycle plus 1 arbitration cycle.
REQ-017 Changes on req bits other than gnt_idx during GRANT or RELEASE SHALL not affect the current grant.
REQ-018 done asserted in IDLE or RELEASE SHALL be ignored.
REQ-019 A requester holding req continuously SHALL be granted within 8 grants (round-robin fairness); no requester may be granted twice while another requester is continuously pending.
REQ-020 gnt_idx SHALL retain its last value while gnt_valid=0.

Reset
REQ-021 Assertion of reset_n=0 SHALL, without waiting for clk, force state=IDLE, ptr=0, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, watchdog count=0.
REQ-022 Reset during GRANT SHALL drop the grant immediately; no release or timeout pulse SHALL follow.
REQ-023 After reset_n deasserts, the first arbitration SHALL search from requester 0.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN SHALL compile the watchdog in or out.
REQ-025 With ARB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to GRANT and increment each GRANT cycle; when it reaches TIMEOUT-1 without done or abandon, the block SHALL enter RELEASE, pulse timeout for one cycle and advance ptr per REQ-015.
REQ-026 With ARB_TIMEOUT_EN defined, done on the same cycle the count reaches TIMEOUT-1 SHALL take priority: normal release, timeout stays 0.
REQ-027 Without ARB_TIMEOUT_EN: no counter is instantiated, timeout SHALL be tied to 0 and a grant SHALL be held indefinitely until done or abandon.

Verification
REQ-028 Reset, req=8'h00 for 5 cycles -> gnt=0, gnt_valid=0, timeout=0 throughout.
REQ-029 req=8'hFF held, done pulsed 1 cycle after each grant -> gnt_idx sequence 0,1,2,...,7,0; gnt one-hot 8'h01,8'h02,...,8'h80,8'h01; RELEASE gap between each.
REQ-030 req=8'h81 held, ptr=7 -> grant idx 7, then after done wrap to idx 0 -> gnt=8'h80 then 8'h01.
REQ-031 ARB_TIMEOUT_EN, TIMEOUT=4, req=8'h04, done never -> gnt=8'h04 for 4 cycles, timeout=1 for 1 cycle, gnt=0, then regrant idx 2.
REQ-032 req=8'h10 granted, deassert req[4] without done -> RELEASE next edge, gnt=0, ptr=5.
REQ-033 reset_n driven low mid-GRANT between clock edges -> gnt, gnt_valid drop to 0 immediately; after release, req=8'hFF -> first grant idx 0.
